// File: rtl/pcs_tx_os_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_os_sequencer_if
// Description : Bundles the transmit-side GMII inputs, mode/config controls
//               and encoder-facing outputs of the ordered-set sequencer.
//               Suffixes are relative to the sequencer (the slave).
// Revision    : 1.0  initial release
// ============================================================================
interface pcs_tx_os_sequencer_if;
    logic [1:0]  xmit_i;
    logic [15:0] tx_config_reg_i;
    logic [7:0]  txd_i;
    logic        tx_en_i;
    logic        tx_er_i;
    logic        rd_neg_i;
    logic [7:0]  tx_code_o;
    logic        tx_k_o;
    logic        tx_even_o;
    logic        cfg_sent_o;
    logic        pkt_active_o;

    modport master (
        output xmit_i, tx_config_reg_i, txd_i, tx_en_i, tx_er_i, rd_neg_i,
        input  tx_code_o, tx_k_o, tx_even_o, cfg_sent_o, pkt_active_o
    );

    modport slave (
        input  xmit_i, tx_config_reg_i, txd_i, tx_en_i, tx_er_i, rd_neg_i,
        output tx_code_o, tx_k_o, tx_even_o, cfg_sent_o, pkt_active_o
    );
endinterface
`default_nettype wire

// File: rtl/pcs_tx_os_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_os_sequencer
// Description : 1000BASE-X PCS transmit ordered-set sequencer. Emits /C1/,/C2/
//               config sets, /I1/,/I2/ idle sets and wraps GMII frames in
//               /S/ ... /T/R/(R/) ahead of the 8b/10b encoder.
// Revision    : 1.0  initial release
// ============================================================================
module pcs_tx_os_sequencer (
    input  wire logic            clk,
    input  wire logic            reset,
    pcs_tx_os_sequencer_if.slave bus
);

    localparam logic [1:0] c_XMIT_CONFIG = 2'b00;
    localparam logic [1:0] c_XMIT_DATA   = 2'b10;

    localparam logic [7:0] c_K28_5 = 8'hBC;
    localparam logic [7:0] c_D21_5 = 8'hB5;
    localparam logic [7:0] c_D2_2  = 8'h42;
    localparam logic [7:0] c_D5_6  = 8'hC5;
    localparam logic [7:0] c_D16_2 = 8'h50;
    localparam logic [7:0] c_SPD   = 8'hFB;
    localparam logic [7:0] c_EPD_T = 8'hFD;
    localparam logic [7:0] c_EPD_R = 8'hF7;
    localparam logic [7:0] c_ERR_V = 8'hFE;

    typedef enum logic [2:0] {
        CFG_C1   = 3'd0,
        CFG_C2   = 3'd1,
        IDLE_SET = 3'd2,
        SOP      = 3'd3,
        DATA     = 3'd4,
        EOP_T    = 3'd5,
        EOP_R    = 3'd6,
        EOP_R2   = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] cfg_q, cfg_d;
    logic        rd_q, rd_d;
    logic        dmode_q, dmode_d;

    logic [7:0]  code_q, code_d;
    logic        k_q, k_d;
    logic        even_q;
    logic        cfg_sent_q, cfg_sent_d;
    logic        pkt_q, pkt_d;

    // Two-stage GMII delay line; stage 2 is the octet being placed now and
    // stage 1 provides a one-octet lookahead for the end of a frame.
    logic [7:0]  txd_p1_q, txd_p2_q;
    logic        en_p1_q, en_p2_q;
    logic        er_p1_q, er_p2_q;

    logic        w_even;

    // The octet produced at the next edge sits in the slot opposite the last.
    assign w_even = ~even_q;

    // GMII delay line, cleared by reset so no stale frame leaks out afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            txd_p1_q <= 8'h00;
            txd_p2_q <= 8'h00;
            en_p1_q  <= 1'b0;
            en_p2_q  <= 1'b0;
            er_p1_q  <= 1'b0;
            er_p2_q  <= 1'b0;
        end else begin
            txd_p1_q <= bus.txd_i;
            txd_p2_q <= txd_p1_q;
            en_p1_q  <= bus.tx_en_i;
            en_p2_q  <= en_p1_q;
            er_p1_q  <= bus.tx_er_i;
            er_p2_q  <= er_p1_q;
        end
    end

    // FSM state, captured set fields and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CFG_C1;
            cnt_q      <= 2'd0;
            cfg_q      <= 16'h0000;
            rd_q       <= 1'b0;
            dmode_q    <= 1'b0;
            code_q     <= 8'h00;
            k_q        <= 1'b0;
            even_q     <= 1'b0;
            cfg_sent_q <= 1'b0;
            pkt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            rd_q       <= rd_d;
            dmode_q    <= dmode_d;
            code_q     <= code_d;
            k_q        <= k_d;
            even_q     <= w_even;
            cfg_sent_q <= cfg_sent_d;
            pkt_q      <= pkt_d;
        end
    end

    // Next-state and next-octet selection. Octet 0 of every /C/ or idle set is
    // the set boundary: it always starts with K28.5 (or /S/ for a frame), so
    // xmit, the config word and rd_neg are all sampled there. CFG_C1/CFG_C2 at
    // octet 0 only records which /C/ flavour is due if config continues.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cfg_d      = cfg_q;
        rd_d       = rd_q;
        dmode_d    = dmode_q;
        code_d     = 8'h00;
        k_d        = 1'b0;
        cfg_sent_d = 1'b0;
        pkt_d      = 1'b0;

        case (state_q)
            CFG_C1, CFG_C2, IDLE_SET: begin
                if (cnt_q == 2'd0) begin
                    cfg_d   = bus.tx_config_reg_i;
                    rd_d    = bus.rd_neg_i;
                    dmode_d = (bus.xmit_i == c_XMIT_DATA);
                    if (bus.xmit_i == c_XMIT_CONFIG) begin
                        code_d  = c_K28_5;
                        k_d     = 1'b1;
                        state_d = (state_q == CFG_C2) ? CFG_C2 : CFG_C1;
                        cnt_d   = 2'd1;
                    end else if ((bus.xmit_i == c_XMIT_DATA) && en_p2_q) begin
                        // Frame starts on an even slot: /S/ overwrites this octet.
                        code_d  = c_SPD;
                        k_d     = 1'b1;
                        pkt_d   = 1'b1;
                        state_d = en_p1_q ? DATA : EOP_T;
                        cnt_d   = 2'd0;
                    end else begin
                        code_d  = c_K28_5;
                        k_d     = 1'b1;
                        state_d = IDLE_SET;
                        cnt_d   = 2'd1;
                    end
                end else if (state_q == IDLE_SET) begin
                    // Second idle octet; a frame arriving here waits one slot.
                    code_d  = rd_q ? c_D16_2 : c_D5_6;
                    cnt_d   = 2'd0;
                    state_d = (dmode_q && en_p2_q) ? SOP : IDLE_SET;
                end else begin
                    case (cnt_q)
                        2'd1:    code_d = (state_q == CFG_C1) ? c_D21_5 : c_D2_2;
                        2'd2:    code_d = cfg_q[7:0];
                        default: begin
                            code_d     = cfg_q[15:8];
                            cfg_sent_d = 1'b1;
                            state_d    = (state_q == CFG_C1) ? CFG_C2 : CFG_C1;
                        end
                    endcase
                    cnt_d = cnt_q + 2'd1;
                end
            end
            SOP: begin
                code_d  = c_SPD;
                k_d     = 1'b1;
                pkt_d   = 1'b1;
                state_d = en_p1_q ? DATA : EOP_T;
            end
            DATA: begin
                code_d  = er_p2_q ? c_ERR_V : txd_p2_q;
                k_d     = er_p2_q;
                pkt_d   = 1'b1;
                state_d = en_p1_q ? DATA : EOP_T;
            end
            EOP_T: begin
                code_d  = c_EPD_T;
                k_d     = 1'b1;
                pkt_d   = 1'b1;
                state_d = EOP_R;
            end
            EOP_R: begin
                // An /R/ in an even slot needs a partner so idle resumes even.
                code_d  = c_EPD_R;
                k_d     = 1'b1;
                pkt_d   = 1'b1;
                state_d = w_even ? EOP_R2 : IDLE_SET;
                cnt_d   = 2'd0;
            end
            EOP_R2: begin
                code_d  = c_EPD_R;
                k_d     = 1'b1;
                pkt_d   = 1'b1;
                state_d = IDLE_SET;
                cnt_d   = 2'd0;
            end
            default: begin
                state_d = CFG_C1;
                cnt_d   = 2'd0;
            end
        endcase
    end

    assign bus.tx_code_o    = code_q;
    assign bus.tx_k_o       = k_q;
    assign bus.tx_even_o    = even_q;
    assign bus.cfg_sent_o   = cfg_sent_q;
    assign bus.pkt_active_o = pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_os_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_tx_os_sequencer
// Description : Self-checking bench for pcs_tx_os_sequencer. A queue-based
//               model turns the input history into the expected octet stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pcs_tx_os_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #4 clk = ~clk;

    pcs_tx_os_sequencer_if bus();

    pcs_tx_os_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       k;
        logic       cs;
        logic       pkt;
        logic       chk;
    } oct_t;

    int   checks = 0;
    int   errors = 0;
    int   n      = 0;

    oct_t q[$];
    logic in_pkt     = 1'b0;
    logic start_next = 1'b0;
    logic c2_next    = 1'b0;
    logic       h1_en = 1'b0, h2_en = 1'b0;
    logic       h1_er = 1'b0, h2_er = 1'b0;
    logic [7:0] h1_d  = 8'h00, h2_d = 8'h00;

    function automatic oct_t mk(input logic [7:0] c, input logic k,
                                input logic cs, input logic pkt, input logic chk);
        oct_t o;
        o.code = c; o.k = k; o.cs = cs; o.pkt = pkt; o.chk = chk;
        return o;
    endfunction

    // One clock: compute the expected octet from the set/frame rules and the
    // input seen two cycles ago, then compare all outputs.
    task automatic cycle();
        logic [7:0] ec;
        logic       ek, ecs, ep, e, r;
        logic [7:0] d;
        oct_t       o;
        @(posedge clk);
        e = h2_en; d = h2_d; r = h2_er;
        ec = 8'h00; ek = 1'b0; ecs = 1'b0; ep = 1'b0;
        if (start_next) begin
            ec = 8'hFB; ek = 1'b1; ep = 1'b1; in_pkt = 1'b1; start_next = 1'b0;
        end else if (in_pkt) begin
            ep = 1'b1;
            if (e) begin
                ec = r ? 8'hFE : d; ek = r;
            end else begin
                ec = 8'hFD; ek = 1'b1; in_pkt = 1'b0;
                q.push_back(mk(8'hF7, 1'b1, 1'b0, 1'b1, 1'b0));
                if (((n + 1) % 2) == 0) q.push_back(mk(8'hF7, 1'b1, 1'b0, 1'b1, 1'b0));
            end
        end else if (q.size() != 0) begin
            o = q.pop_front();
            ec = o.code; ek = o.k; ecs = o.cs; ep = o.pkt;
            if (o.chk && e) start_next = 1'b1;
        end else if (bus.xmit_i == 2'b00) begin
            ec = 8'hBC; ek = 1'b1;
            q.push_back(mk(c2_next ? 8'h42 : 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(bus.tx_config_reg_i[7:0], 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(bus.tx_config_reg_i[15:8], 1'b0, 1'b1, 1'b0, 1'b0));
            c2_next = ~c2_next;
        end else if ((bus.xmit_i == 2'b10) && e) begin
            ec = 8'hFB; ek = 1'b1; ep = 1'b1; in_pkt = 1'b1; c2_next = 1'b0;
        end else begin
            ec = 8'hBC; ek = 1'b1; c2_next = 1'b0;
            q.push_back(mk(bus.rd_neg_i ? 8'h50 : 8'hC5, 1'b0, 1'b0, 1'b0,
                           bus.xmit_i == 2'b10));
        end
        h2_en = h1_en; h2_d = h1_d; h2_er = h1_er;
        h1_en = bus.tx_en_i; h1_d = bus.txd_i; h1_er = bus.tx_er_i;
        #1;
        checks++;
        if ({bus.tx_code_o, bus.tx_k_o, bus.tx_even_o, bus.cfg_sent_o, bus.pkt_active_o}
            !== {ec, ek, ((n % 2) == 0), ecs, ep}) begin
            errors++;
            $display("FAIL octet n=%0d: got code=%h k=%b even=%b cfg_sent=%b pkt=%b, expected code=%h k=%b even=%b cfg_sent=%b pkt=%b",
                     n, bus.tx_code_o, bus.tx_k_o, bus.tx_even_o, bus.cfg_sent_o,
                     bus.pkt_active_o, ec, ek, ((n % 2) == 0), ecs, ep);
        end
        n++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    task automatic test_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.tx_code_o, bus.tx_k_o, bus.tx_even_o, bus.cfg_sent_o, bus.pkt_active_o} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs: got code=%h k=%b even=%b cfg_sent=%b pkt=%b, expected all zero",
                         bus.tx_code_o, bus.tx_k_o, bus.tx_even_o, bus.cfg_sent_o, bus.pkt_active_o);
            end
        end
        q.delete();
        in_pkt = 1'b0; start_next = 1'b0; c2_next = 1'b0; n = 0;
        h1_en = 1'b0; h2_en = 1'b0; h1_er = 1'b0; h2_er = 1'b0; h1_d = 8'h00; h2_d = 8'h00;
        reset = 1'b0;
    endtask

    task automatic test_config();
        logic [7:0] exp_code [8];
        exp_code = '{8'hBC, 8'hB5, 8'hA0, 8'h41, 8'hBC, 8'h42, 8'hA0, 8'h41};
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if ({bus.tx_code_o, bus.cfg_sent_o} !== {exp_code[i], (i % 4) == 3}) begin
                errors++;
                $display("FAIL config_seq[%0d]: got code=%h cfg_sent=%b, expected code=%h cfg_sent=%b",
                         i, bus.tx_code_o, bus.cfg_sent_o, exp_code[i], (i % 4) == 3);
            end
        end
        run(8);
    endtask

    task automatic test_cfg_change();
        logic [7:0] exp_code [6];
        exp_code = '{8'hA0, 8'h41, 8'hBC, 8'h00, 8'h01, 8'h00};
        while ((n % 4) != 2) cycle();
        bus.tx_config_reg_i = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i != 3) begin
                checks++;
                if (bus.tx_code_o !== exp_code[i]) begin
                    errors++;
                    $display("FAIL cfg_change[%0d]: got code=%h, expected code=%h",
                             i, bus.tx_code_o, exp_code[i]);
                end
            end
        end
        bus.tx_config_reg_i = 16'($urandom);
        run(8);
    endtask

    task automatic test_idle();
        bus.xmit_i = 2'b01;
        for (int i = 0; i < 24; i++) begin
            bus.rd_neg_i = 1'($urandom);
            bus.tx_en_i  = 1'($urandom);
            bus.txd_i    = 8'($urandom);
            if (i == 12) bus.xmit_i = 2'b11;
            cycle();
        end
        bus.tx_en_i = 1'b0;
        bus.xmit_i  = 2'b01;
        run(4);
    endtask

    task automatic test_xmit_change();
        while ((n % 2) != 1) cycle();
        bus.xmit_i = 2'b10;
        run(8);
    endtask

    task automatic send_frame(input int len, input bit rnd, input int er_pos,
                              input int sw_pos, input logic [1:0] sw_xmit);
        for (int i = 0; i < len; i++) begin
            bus.tx_en_i = 1'b1;
            bus.txd_i   = rnd ? 8'($urandom) : ((i == len - 1) ? 8'hD5 : 8'h55);
            bus.tx_er_i = (i == er_pos);
            if (i == sw_pos) bus.xmit_i = sw_xmit;
            cycle();
        end
        bus.tx_en_i = 1'b0;
        bus.tx_er_i = 1'b0;
        bus.txd_i   = 8'h00;
    endtask

    task automatic test_frames();
        bus.xmit_i = 2'b10;
        run(4);
        while ((n % 2) != 0) cycle();
        send_frame(8, 1'b0, -1, -1, 2'b10);
        run(8);
        while ((n % 2) != 1) cycle();
        send_frame(8, 1'b0, -1, -1, 2'b10);
        run(8);
        while ((n % 2) != 0) cycle();
        send_frame(8, 1'b0, 3, -1, 2'b10);
        run(8);
        for (int f = 0; f < 8; f++) begin
            bus.rd_neg_i = 1'($urandom);
            if ($urandom_range(0, 1) == 1) cycle();
            send_frame($urandom_range(1, 20), 1'b1,
                       ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1, -1, 2'b10);
            run($urandom_range(6, 12));
        end
    endtask

    task automatic test_xmit_mid_frame();
        send_frame(10, 1'b1, -1, 4, 2'b00);
        run(14);
        bus.xmit_i = 2'b10;
        run(8);
    endtask

    task automatic test_reset_mid_frame();
        while ((n % 2) != 1) cycle();
        send_frame(12, 1'b1, -1, -1, 2'b10);
        bus.tx_en_i = 1'b1;
        cycle();
        bus.tx_en_i = 1'b0;
        test_reset(3);
        run(8);
        bus.xmit_i = 2'b00;
        run(10);
    endtask

    initial begin
        bus.xmit_i          = 2'b00;
        bus.tx_config_reg_i = 16'h41A0;
        bus.txd_i           = 8'h00;
        bus.tx_en_i         = 1'b0;
        bus.tx_er_i         = 1'b0;
        bus.rd_neg_i        = 1'b0;
        test_reset(3);
        test_config();
        test_cfg_change();
        test_idle();
        test_xmit_change();
        test_frames();
        test_xmit_mid_frame();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
